// File: rtl/boreal_dma_engine.sv
// rtl/boreal_dma_engine.sv - word-granular memory-to-memory DMA copy engine
// Issues single-beat reads/writes on a lossy fixed-latency port; dropped beats are recovered by timeout and retry.
module boreal_dma_engine #(
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 3,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic [2:0]       err_code,
  output logic [31:0]      err_addr,
  output logic [LEN_W-1:0] words_done,
  output logic             dma_req_valid,
  output logic             dma_req_we,
  output logic [31:0]      dma_req_addr,
  output logic [31:0]      dma_req_wdata,
  output logic [3:0]       dma_req_wstrb,
  input  logic             dma_resp_valid,
  input  logic [31:0]      dma_resp_rdata,
  input  logic             dma_resp_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_t;

  state_t state, next_state;

  logic [31:0]      src, dst, rdata_q;
  logic [LEN_W-1:0] remaining;
  logic [RW-1:0]    retry;
  logic [TW-1:0]    timer;

  logic [31:0]      src_n, dst_n, rdata_n, err_addr_n;
  logic [LEN_W-1:0] remaining_n, words_done_n;
  logic [RW-1:0]    retry_n;
  logic [TW-1:0]    timer_n;
  logic [2:0]       err_code_n;
  logic             done_n;
  logic             req_valid_n, req_we_n;
  logic [31:0]      req_addr_n, req_wdata_n;
  logic [3:0]       req_wstrb_n;

  logic misaligned, accept, abort, resp_ok, resp_bad, timed_out, can_retry, in_rd;

  assign misaligned = (cfg_src[1:0] != 2'b00) || (cfg_dst[1:0] != 2'b00);
  assign accept     = cfg_start && !misaligned && (cfg_len != '0);
  assign abort      = (state != IDLE) && cfg_abort;
  assign resp_ok    = dma_resp_valid && !dma_resp_err;
  assign resp_bad   = dma_resp_valid && dma_resp_err;
  assign timed_out  = !dma_resp_valid && (timer == TW'(TIMEOUT - 1));
  assign can_retry  = retry < RW'(MAX_RETRY);
  assign in_rd      = (state == RD_REQ) || (state == RD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RD_REQ;
      RD_REQ:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (resp_ok)        next_state = WR_REQ;
        else if (resp_bad)  next_state = IDLE;
        else if (timed_out) next_state = can_retry ? RD_REQ : IDLE;
      end
      WR_REQ:  next_state = WR_WAIT;
      WR_WAIT: begin
        if (resp_ok)        next_state = (remaining == LEN_W'(1)) ? IDLE : RD_REQ;
        else if (resp_bad)  next_state = IDLE;
        else if (timed_out) next_state = can_retry ? WR_REQ : IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Next values of every registered output and datapath register; request fields are
  // derived from the post-update addresses so a request goes out in its REQ cycle.
  always_comb begin
    src_n        = src;
    dst_n        = dst;
    rdata_n      = rdata_q;
    remaining_n  = remaining;
    retry_n      = retry;
    timer_n      = timer;
    words_done_n = words_done;
    err_code_n   = err_code;
    err_addr_n   = err_addr;
    done_n       = 1'b0;
    if (abort) begin
      err_code_n = 3'd4;
      err_addr_n = in_rd ? src : dst;
      done_n     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (misaligned) begin
              err_code_n = 3'd3;
              err_addr_n = (cfg_src[1:0] != 2'b00) ? cfg_src : cfg_dst;
              done_n     = 1'b1;
            end else if (cfg_len == '0) begin
              err_code_n = 3'd0;
              done_n     = 1'b1;
            end else begin
              src_n        = cfg_src;
              dst_n        = cfg_dst;
              remaining_n  = cfg_len;
              words_done_n = '0;
              err_code_n   = 3'd0;
              err_addr_n   = 32'h0;
              retry_n      = '0;
            end
          end
        end
        RD_REQ, WR_REQ: timer_n = '0;
        RD_WAIT: begin
          timer_n = timer + TW'(1);
          if (resp_ok) begin
            rdata_n = dma_resp_rdata;
            retry_n = '0;
          end else if (resp_bad) begin
            err_code_n = 3'd1;
            err_addr_n = src;
            done_n     = 1'b1;
          end else if (timed_out) begin
            if (can_retry) begin
              retry_n = retry + RW'(1);
            end else begin
              err_code_n = 3'd2;
              err_addr_n = src;
              done_n     = 1'b1;
            end
          end
        end
        WR_WAIT: begin
          timer_n = timer + TW'(1);
          if (resp_ok) begin
            words_done_n = words_done + LEN_W'(1);
            src_n        = src + 32'd4;
            dst_n        = dst + 32'd4;
            remaining_n  = remaining - LEN_W'(1);
            retry_n      = '0;
            if (remaining == LEN_W'(1)) done_n = 1'b1;
          end else if (resp_bad) begin
            err_code_n = 3'd1;
            err_addr_n = dst;
            done_n     = 1'b1;
          end else if (timed_out) begin
            if (can_retry) begin
              retry_n = retry + RW'(1);
            end else begin
              err_code_n = 3'd2;
              err_addr_n = dst;
              done_n     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    req_valid_n = 1'b0;
    req_we_n    = 1'b0;
    req_addr_n  = 32'h0;
    req_wdata_n = 32'h0;
    req_wstrb_n = 4'h0;
    if (next_state == RD_REQ) begin
      req_valid_n = 1'b1;
      req_addr_n  = src_n;
    end else if (next_state == WR_REQ) begin
      req_valid_n = 1'b1;
      req_we_n    = 1'b1;
      req_addr_n  = dst_n;
      req_wdata_n = rdata_n;
      req_wstrb_n = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src           <= 32'h0;
      dst           <= 32'h0;
      rdata_q       <= 32'h0;
      remaining     <= '0;
      retry         <= '0;
      timer         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_code      <= 3'd0;
      err_addr      <= 32'h0;
      words_done    <= '0;
      dma_req_valid <= 1'b0;
      dma_req_we    <= 1'b0;
      dma_req_addr  <= 32'h0;
      dma_req_wdata <= 32'h0;
      dma_req_wstrb <= 4'h0;
    end else begin
      src           <= src_n;
      dst           <= dst_n;
      rdata_q       <= rdata_n;
      remaining     <= remaining_n;
      retry         <= retry_n;
      timer         <= timer_n;
      busy          <= (next_state != IDLE);
      done          <= done_n;
      err_code      <= err_code_n;
      err_addr      <= err_addr_n;
      words_done    <= words_done_n;
      dma_req_valid <= req_valid_n;
      dma_req_we    <= req_we_n;
      dma_req_addr  <= req_addr_n;
      dma_req_wdata <= req_wdata_n;
      dma_req_wstrb <= req_wstrb_n;
    end
  end

endmodule
